// File: rtl/ptw_axi_arbiter.sv
// Round-robin arbiter that lets the ITLB and DTLB page-table walkers share
// one AXI read port, with one read outstanding and a watchdog on each read.
module ptw_axi_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_WIDTH  = 11
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FLUSH,
  input  logic                  ITLB_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] ITLB_REQ_ADDR,
  output logic                  ITLB_RSP_VALID,
  output logic [DATA_WIDTH-1:0] ITLB_RSP_DATA,
  output logic                  ITLB_RSP_ERR,
  input  logic                  DTLB_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] DTLB_REQ_ADDR,
  output logic                  DTLB_RSP_VALID,
  output logic [DATA_WIDTH-1:0] DTLB_RSP_DATA,
  output logic                  DTLB_RSP_ERR,
  output logic                  AXIM_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0] AXIM_ADDR,
  input  logic                  AXIM_ADDR_READY,
  input  logic                  AXIM_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] AXIM_DATA,
  output logic                  BUSY,
  output logic                  GRANT
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_n;
  logic                   pend_itlb_q, pend_itlb_n;
  logic                   pend_dtlb_q, pend_dtlb_n;
  logic [ADDR_WIDTH-1:0]  addr_itlb_q, addr_itlb_n;
  logic [ADDR_WIDTH-1:0]  addr_dtlb_q, addr_dtlb_n;
  logic                   last_q, last_n;
  logic                   grant_q, grant_n;
  logic                   aw_valid_q, aw_valid_n;
  logic [ADDR_WIDTH-1:0]  aw_addr_q, aw_addr_n;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_n;
  logic                   disc_q, disc_n;
  logic                   irv_q, irv_n;
  logic                   ire_q, ire_n;
  logic [DATA_WIDTH-1:0]  ird_q, ird_n;
  logic                   drv_q, drv_n;
  logic                   dre_q, dre_n;
  logic [DATA_WIDTH-1:0]  drd_q, drd_n;
  logic                   cand_i, cand_d, owner;
  logic                   drop;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      pend_itlb_q <= 1'b0;
      pend_dtlb_q <= 1'b0;
      addr_itlb_q <= '0;
      addr_dtlb_q <= '0;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      aw_valid_q  <= 1'b0;
      aw_addr_q   <= '0;
      cnt_q       <= '0;
      disc_q      <= 1'b0;
      irv_q       <= 1'b0;
      ire_q       <= 1'b0;
      ird_q       <= '0;
      drv_q       <= 1'b0;
      dre_q       <= 1'b0;
      drd_q       <= '0;
    end else begin
      state_q     <= state_n;
      pend_itlb_q <= pend_itlb_n;
      pend_dtlb_q <= pend_dtlb_n;
      addr_itlb_q <= addr_itlb_n;
      addr_dtlb_q <= addr_dtlb_n;
      last_q      <= last_n;
      grant_q     <= grant_n;
      aw_valid_q  <= aw_valid_n;
      aw_addr_q   <= aw_addr_n;
      cnt_q       <= cnt_n;
      disc_q      <= disc_n;
      irv_q       <= irv_n;
      ire_q       <= ire_n;
      ird_q       <= ird_n;
      drv_q       <= drv_n;
      dre_q       <= dre_n;
      drd_q       <= drd_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    pend_itlb_n = pend_itlb_q;
    pend_dtlb_n = pend_dtlb_q;
    addr_itlb_n = addr_itlb_q;
    addr_dtlb_n = addr_dtlb_q;
    last_n      = last_q;
    grant_n     = grant_q;
    aw_valid_n  = aw_valid_q;
    aw_addr_n   = aw_addr_q;
    cnt_n       = cnt_q;
    disc_n      = disc_q;
    irv_n       = 1'b0;
    ire_n       = 1'b0;
    ird_n       = ird_q;
    drv_n       = 1'b0;
    dre_n       = 1'b0;
    drd_n       = drd_q;
    cand_i      = pend_itlb_q | ITLB_REQ_VALID;
    cand_d      = pend_dtlb_q | DTLB_REQ_VALID;
    owner       = (cand_i && cand_d) ? ~last_q : cand_d;
    drop        = disc_q | FLUSH;

    // FLUSH beats a same-cycle request pulse
    if (FLUSH) begin
      pend_itlb_n = 1'b0;
      pend_dtlb_n = 1'b0;
    end else begin
      if (ITLB_REQ_VALID) begin
        pend_itlb_n = 1'b1;
        addr_itlb_n = ITLB_REQ_ADDR;
      end
      if (DTLB_REQ_VALID) begin
        pend_dtlb_n = 1'b1;
        addr_dtlb_n = DTLB_REQ_ADDR;
      end
    end

    case (state_q)
      IDLE: begin
        // arbitration only starts once a pend is registered
        if (!FLUSH && (pend_itlb_q || pend_dtlb_q)) begin
          grant_n    = owner;
          aw_valid_n = 1'b1;
          disc_n     = 1'b0;
          state_n    = ISSUE;
          if (owner) begin
            aw_addr_n   = addr_dtlb_n;
            pend_dtlb_n = 1'b0;
          end else begin
            aw_addr_n   = addr_itlb_n;
            pend_itlb_n = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (FLUSH) disc_n = 1'b1;
        if (AXIM_ADDR_READY) begin
          aw_valid_n = 1'b0;
          cnt_n      = '0;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (FLUSH) disc_n = 1'b1;
        if (AXIM_DATA_VALID || cnt_q == CNT_LAST) begin
          if (!drop) begin
            if (grant_q) begin
              drv_n = 1'b1;
              dre_n = ~AXIM_DATA_VALID;
              drd_n = AXIM_DATA_VALID ? AXIM_DATA : '0;
            end else begin
              irv_n = 1'b1;
              ire_n = ~AXIM_DATA_VALID;
              ird_n = AXIM_DATA_VALID ? AXIM_DATA : '0;
            end
          end
          last_n  = grant_q;
          disc_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ITLB_RSP_VALID  = irv_q;
  assign ITLB_RSP_ERR    = ire_q;
  assign ITLB_RSP_DATA   = ird_q;
  assign DTLB_RSP_VALID  = drv_q;
  assign DTLB_RSP_ERR    = dre_q;
  assign DTLB_RSP_DATA   = drd_q;
  assign AXIM_ADDR_VALID = aw_valid_q;
  assign AXIM_ADDR       = aw_addr_q;
  assign BUSY            = (state_q != IDLE);
  assign GRANT           = grant_q;

endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// Directed bench for ptw_axi_arbiter: vector table plus
// hand-written arbitration, timeout, flush and reset sequences.
module tb_ptw_axi_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic        ITLB_REQ_VALID = 1'b0;
  logic [63:0] ITLB_REQ_ADDR = '0;
  logic        ITLB_RSP_VALID;
  logic [63:0] ITLB_RSP_DATA;
  logic        ITLB_RSP_ERR;
  logic        DTLB_REQ_VALID = 1'b0;
  logic [63:0] DTLB_REQ_ADDR = '0;
  logic        DTLB_RSP_VALID;
  logic [63:0] DTLB_RSP_DATA;
  logic        DTLB_RSP_ERR;
  logic        AXIM_ADDR_VALID;
  logic [63:0] AXIM_ADDR;
  logic        AXIM_ADDR_READY = 1'b0;
  logic        AXIM_DATA_VALID = 1'b0;
  logic [63:0] AXIM_DATA = '0;
  logic        BUSY;
  logic        GRANT;

  int checks = 0;
  int errors = 0;

  ptw_axi_arbiter #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_WIDTH(4)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .FLUSH(FLUSH),
    .ITLB_REQ_VALID(ITLB_REQ_VALID),
    .ITLB_REQ_ADDR(ITLB_REQ_ADDR),
    .ITLB_RSP_VALID(ITLB_RSP_VALID),
    .ITLB_RSP_DATA(ITLB_RSP_DATA),
    .ITLB_RSP_ERR(ITLB_RSP_ERR),
    .DTLB_REQ_VALID(DTLB_REQ_VALID),
    .DTLB_REQ_ADDR(DTLB_REQ_ADDR),
    .DTLB_RSP_VALID(DTLB_RSP_VALID),
    .DTLB_RSP_DATA(DTLB_RSP_DATA),
    .DTLB_RSP_ERR(DTLB_RSP_ERR),
    .AXIM_ADDR_VALID(AXIM_ADDR_VALID),
    .AXIM_ADDR(AXIM_ADDR),
    .AXIM_ADDR_READY(AXIM_ADDR_READY),
    .AXIM_DATA_VALID(AXIM_DATA_VALID),
    .AXIM_DATA(AXIM_DATA),
    .BUSY(BUSY),
    .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        irq;
    logic [63:0] iaddr;
    logic        drq;
    logic [63:0] daddr;
    logic        flush;
    logic        ready;
    logic        dv;
    logic [63:0] data;
    logic        e_awv;
    logic [63:0] e_awa;
    logic        e_irv;
    logic        e_ire;
    logic [63:0] e_ird;
    logic        e_drv;
    logic        e_dre;
    logic        e_busy;
    logic        e_grant;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " irv"}, 64'(ITLB_RSP_VALID), 64'd0);
    chk({tag, " drv"}, 64'(DTLB_RSP_VALID), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " awv"}, 64'(AXIM_ADDR_VALID), 64'd0);
    chk({tag, " awa"}, AXIM_ADDR, 64'd0);
    chk({tag, " ird"}, ITLB_RSP_DATA, 64'd0);
    chk({tag, " drd"}, DTLB_RSP_DATA, 64'd0);
    chk({tag, " ire"}, 64'(ITLB_RSP_ERR), 64'd0);
    chk({tag, " dre"}, 64'(DTLB_RSP_ERR), 64'd0);
    chk({tag, " busy"}, 64'(BUSY), 64'd0);
    chk({tag, " grant"}, 64'(GRANT), 64'd0);
    chk_quiet(tag);
  endtask

  task automatic pulse(input logic i, input logic [63:0] ia,
                       input logic d, input logic [63:0] da);
    ITLB_REQ_VALID = i;
    ITLB_REQ_ADDR  = ia;
    DTLB_REQ_VALID = d;
    DTLB_REQ_ADDR  = da;
    tick();
    ITLB_REQ_VALID = 1'b0;
    DTLB_REQ_VALID = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic [63:0] a,
                              input logic g);
    for (int k = 0; k < 20 && !AXIM_ADDR_VALID; k++) tick();
    chk({tag, " awv"}, 64'(AXIM_ADDR_VALID), 64'd1);
    chk({tag, " awa"}, AXIM_ADDR, a);
    chk({tag, " grant"}, 64'(GRANT), 64'(g));
    chk({tag, " busy"}, 64'(BUSY), 64'd1);
  endtask

  task automatic accept();
    AXIM_ADDR_READY = 1'b1;
    tick();
    AXIM_ADDR_READY = 1'b0;
  endtask

  task automatic respond(input string tag, input logic [63:0] d,
                         input logic own);
    AXIM_DATA_VALID = 1'b1;
    AXIM_DATA       = d;
    tick();
    AXIM_DATA_VALID = 1'b0;
    chk({tag, " irv"}, 64'(ITLB_RSP_VALID), 64'(!own));
    chk({tag, " drv"}, 64'(DTLB_RSP_VALID), 64'(own));
    chk({tag, " data"}, own ? DTLB_RSP_DATA : ITLB_RSP_DATA, d);
    chk({tag, " err"}, 64'(own ? DTLB_RSP_ERR : ITLB_RSP_ERR), 64'd0);
    chk({tag, " busy"}, 64'(BUSY), 64'd0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    //        irq iaddr                drq daddr fl rdy dv data
    //        awv awa                  irv ire ird         drv dre busy gnt
    vecs[0] = '{1'b1, 64'h0000_0000_8000_1008, 1'b0, 64'h0, 1'b0, 1'b0,
                1'b0, 64'h0,
                1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,
                1'b1, 64'h0000_0000_8000_1008, 1'b0, 1'b0, 64'h0,
                1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,
                1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1,
                64'h2000_04CF,
                1'b0, 64'h0, 1'b1, 1'b0, 64'h2000_04CF, 1'b0, 1'b0,
                1'b0, 1'b0};
    vecs[6] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 64'h900, 1'b1, 64'h980, 1'b1, 1'b0, 1'b0, 64'h0,
                1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk_zero("reset");

    for (int v = 0; v < 10; v++) begin
      ITLB_REQ_VALID  = vecs[v].irq;
      ITLB_REQ_ADDR   = vecs[v].iaddr;
      DTLB_REQ_VALID  = vecs[v].drq;
      DTLB_REQ_ADDR   = vecs[v].daddr;
      FLUSH           = vecs[v].flush;
      AXIM_ADDR_READY = vecs[v].ready;
      AXIM_DATA_VALID = vecs[v].dv;
      AXIM_DATA       = vecs[v].data;
      tick();
      chk($sformatf("v%0d awv", v), 64'(AXIM_ADDR_VALID),
          64'(vecs[v].e_awv));
      if (vecs[v].e_awv)
        chk($sformatf("v%0d awa", v), AXIM_ADDR, vecs[v].e_awa);
      chk($sformatf("v%0d irv", v), 64'(ITLB_RSP_VALID),
          64'(vecs[v].e_irv));
      chk($sformatf("v%0d ire", v), 64'(ITLB_RSP_ERR), 64'(vecs[v].e_ire));
      if (vecs[v].e_irv)
        chk($sformatf("v%0d ird", v), ITLB_RSP_DATA, vecs[v].e_ird);
      chk($sformatf("v%0d drv", v), 64'(DTLB_RSP_VALID),
          64'(vecs[v].e_drv));
      chk($sformatf("v%0d dre", v), 64'(DTLB_RSP_ERR), 64'(vecs[v].e_dre));
      chk($sformatf("v%0d busy", v), 64'(BUSY), 64'(vecs[v].e_busy));
      chk($sformatf("v%0d grant", v), 64'(GRANT), 64'(vecs[v].e_grant));
    end
    ITLB_REQ_VALID  = 1'b0;
    DTLB_REQ_VALID  = 1'b0;
    FLUSH           = 1'b0;
    AXIM_ADDR_READY = 1'b0;
    AXIM_DATA_VALID = 1'b0;

    // round-robin: tie after reset goes to ITLB, then alternates
    do_reset();
    pulse(1'b1, 64'hA000, 1'b1, 64'hB000);
    expect_issue("rr1a", 64'hA000, 1'b0);
    accept();
    respond("rr1a", 64'h11, 1'b0);
    expect_issue("rr1b", 64'hB000, 1'b1);
    accept();
    respond("rr1b", 64'h22, 1'b1);
    pulse(1'b1, 64'hA100, 1'b1, 64'hB100);
    expect_issue("rr2a", 64'hA100, 1'b0);
    accept();
    respond("rr2a", 64'h33, 1'b0);
    expect_issue("rr2b", 64'hB100, 1'b1);
    accept();
    respond("rr2b", 64'h44, 1'b1);
    pulse(1'b1, 64'hA200, 1'b0, 64'h0);
    expect_issue("rr3", 64'hA200, 1'b0);
    accept();
    respond("rr3", 64'h55, 1'b0);
    pulse(1'b1, 64'hA300, 1'b1, 64'hB300);
    expect_issue("rr4a", 64'hB300, 1'b1);
    accept();
    respond("rr4a", 64'h66, 1'b1);
    expect_issue("rr4b", 64'hA300, 1'b0);
    accept();
    respond("rr4b", 64'h77, 1'b0);

    // second pulse before grant overwrites the address
    pulse(1'b0, 64'h0, 1'b1, 64'h100);
    pulse(1'b0, 64'h0, 1'b1, 64'h200);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ovw hold%0d awv", k), 64'(AXIM_ADDR_VALID), 64'd1);
      chk($sformatf("ovw hold%0d awa", k), AXIM_ADDR, 64'h200);
      tick();
    end
    accept();
    chk("ovw drop awv", 64'(AXIM_ADDR_VALID), 64'd0);
    respond("ovw", 64'h88, 1'b1);
    tick();
    tick();
    chk("ovw once awv", 64'(AXIM_ADDR_VALID), 64'd0);
    chk("ovw once busy", 64'(BUSY), 64'd0);

    // watchdog abort after 8 cycles in WAIT
    pulse(1'b1, 64'h300, 1'b0, 64'h0);
    expect_issue("to", 64'h300, 1'b0);
    accept();
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("to w%0d irv", k), 64'(ITLB_RSP_VALID), 64'd0);
      chk($sformatf("to w%0d busy", k), 64'(BUSY), 64'd1);
    end
    tick();
    chk("to irv", 64'(ITLB_RSP_VALID), 64'd1);
    chk("to ire", 64'(ITLB_RSP_ERR), 64'd1);
    chk("to ird", ITLB_RSP_DATA, 64'd0);
    chk("to drv", 64'(DTLB_RSP_VALID), 64'd0);
    chk("to busy", 64'(BUSY), 64'd0);
    tick();
    chk("to pulse irv", 64'(ITLB_RSP_VALID), 64'd0);
    chk("to pulse ire", 64'(ITLB_RSP_ERR), 64'd0);
    AXIM_DATA_VALID = 1'b1;
    AXIM_DATA       = 64'hDEAD;
    tick();
    AXIM_DATA_VALID = 1'b0;
    chk_quiet("to late");
    chk("to late busy", 64'(BUSY), 64'd0);

    // flush in WAIT discards DTLB data and drops pending ITLB
    pulse(1'b0, 64'h0, 1'b1, 64'h400);
    expect_issue("fl", 64'h400, 1'b1);
    accept();
    pulse(1'b1, 64'h500, 1'b0, 64'h0);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    AXIM_DATA_VALID = 1'b1;
    AXIM_DATA       = 64'hBEEF;
    tick();
    AXIM_DATA_VALID = 1'b0;
    chk_quiet("fl rsp");
    chk("fl busy", 64'(BUSY), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fl idle%0d awv", k), 64'(AXIM_ADDR_VALID), 64'd0);
      chk($sformatf("fl idle%0d busy", k), 64'(BUSY), 64'd0);
      chk_quiet($sformatf("fl idle%0d", k));
    end

    // reset mid-WAIT abandons the read
    pulse(1'b1, 64'h600, 1'b0, 64'h0);
    expect_issue("rst", 64'h600, 1'b0);
    accept();
    tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk_zero("rst mid");
    AXIM_DATA_VALID = 1'b1;
    AXIM_DATA       = 64'hCAFE;
    tick();
    AXIM_DATA_VALID = 1'b0;
    chk_zero("rst late");
    pulse(1'b1, 64'h700, 1'b1, 64'h780);
    expect_issue("rst new", 64'h700, 1'b0);
    accept();
    respond("rst new", 64'h99, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
